pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Hazard/stall controller for the ID->EXE->MEM->WB vector pipeline. Compares ID-stage source regs
//  against destinations in EXE/MEM/WB and selects operand forwarding for the EXE stage.
//  Drives PC/IF-ID hold and bubble insertion into the ID/EXE register on load-use hazards.
//  Freezes the whole pipeline while data memory is busy, and counts stall cycles.
// PARAMETERS
//  ADDR_W      3   register address width (vector and scalar files share it)
//  LOAD_STALL  2   load-use stall cycles, legal 1..3 (load data first forwardable from WB)
//  CNT_W       16  stall counter width
// PORTS
//  clk           in   1       clock, all state updates on posedge
//  rst           in   1       synchronous reset, active-high
//  id_valid      in   1       ID stage holds a valid instruction
//  id_vs1/id_vs2 in   ADDR_W  ID vector source addresses
//  id_use_vs1/2  in   1       corresponding vector source is read
//  id_ss1        in   ADDR_W  ID scalar source address; id_use_ss1 in 1: it is read
//  ex_valid      in   1       EXE stage valid; ex_dest in ADDR_W; ex_wrv/ex_wrs in 1 (vector/scalar write)
//  ex_load       in   1       EXE instruction reads data memory
//  mem_valid     in   1       MEM stage valid; mem_dest ADDR_W; mem_wrv/mem_wrs 1; mem_load 1
//  wb_valid      in   1       WB stage valid; wb_dest ADDR_W; wb_wrv/wb_wrs 1
//  mem_busy      in   1       data memory cannot complete this cycle
//  stall_if      out  1       hold PC and IF/ID register
//  bubble_ex     out  1       force all ID/EXE control bits to 0 at next capture
//  freeze_all    out  1       hold every pipeline register
//  fwd_vs1/vs2/ss1 out 2     operand source: 00 regfile, 01 MEM stage, 10 WB stage
//  state         out  2       00 RUN, 01 LU, 10 MEMWAIT
//  stall_cnt     out  CNT_W   stall-cycle count, saturating
// BEHAVIOUR
//  - Reset: while rst=1 all outputs 0 regardless of inputs. Next cycle: RUN, lu_cnt=0, stall_cnt=0.
//    rst mid-operation aborts LU/MEMWAIT immediately.
//  - Match: vector sources match only stages with wrv=1; scalar source matches only wrs=1.
//    Stage valid must be 1 and addresses equal. The two namespaces never alias. No hardwired-zero reg.
//  - Forwarding (combinational): MEM match beats WB match, else 00. A MEM match with mem_load=1 is
//    not forwarded (falls to WB/regfile); the LU stall covers it.
//  - Load-use hazard: id_valid & ex_valid & ex_load & match on any used source against EXE dest.
//  - stall_if/bubble_ex/freeze_all are Mealy outputs of state and current inputs. Never
//    bubble_ex and freeze_all together.
//  - RUN:
//      mem_busy=1: freeze_all=1; ret<=RUN; next MEMWAIT. mem_busy beats a simultaneous hazard.
//      Else load-use hazard: stall_if=bubble_ex=1; lu_cnt<=LOAD_STALL-1;
//        next LU if LOAD_STALL>1, else RUN.
//      Else all outputs 0.
//  - LU:
//      mem_busy=1: freeze_all=1 only; lu_cnt held; ret<=LU; next MEMWAIT.
//      Else stall_if=bubble_ex=1 and lu_cnt decrements; next RUN when lu_cnt==1.
//      No hazard rescan in LU.
//  - MEMWAIT: freeze_all=1 while mem_busy=1. First cycle mem_busy=0: outputs evaluated as in ret
//    state, and the state machine transitions as ret would.
//  - stall_cnt: +1 on every cycle with stall_if|freeze_all=1; saturates at 2^CNT_W-1, never wraps.
// TESTING
//  1 rst=1 with mem_busy=1 and a live hazard -> all outputs 0. After release: state=00, stall_cnt=0.
//  2 mem_valid,mem_wrv,mem_dest=3 and wb_valid,wb_wrv,wb_dest=3, id_vs1=3 used -> fwd_vs1=01.
//    Drop mem_valid -> fwd_vs1=10.
//  3 ex_load,ex_wrv,ex_dest=5, id_vs2=5 used, LOAD_STALL=2 -> stall_if=bubble_ex=1 for exactly
//    2 cycles (RUN,LU), then 0; stall_cnt=2.
//  4 As 3, but mem_busy=1 for 3 cycles starting in LU -> freeze_all 3 cycles, bubble_ex=0 there.
//    Then 1 remaining LU stall cycle; stall_cnt=5.
//  5 ex_load,ex_wrs,ex_dest=5, id_vs1=5 used, id_use_ss1=0 -> no stall, fwd_vs1=00.
//  6 CNT_W=4, mem_busy=1 for 20 cycles -> stall_cnt=15 and holds; freeze_all drops first idle cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the ID->EXE->MEM->WB vector pipeline.
// It selects the EXE operand forwarding sources and detects load-use hazards,
// which it resolves by holding IF/ID and inserting bubbles into ID/EXE.
// While data memory is busy it freezes the whole pipeline.
// It also counts stall cycles with a saturating counter.
module pipe_hazard_ctrl #(
  parameter int ADDR_W     = 3,
  parameter int LOAD_STALL = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_vs1,
  input  logic [ADDR_W-1:0] id_vs2,
  input  logic              id_use_vs1,
  input  logic              id_use_vs2,
  input  logic [ADDR_W-1:0] id_ss1,
  input  logic              id_use_ss1,
  input  logic              ex_valid,
  input  logic [ADDR_W-1:0] ex_dest,
  input  logic              ex_wrv,
  input  logic              ex_wrs,
  input  logic              ex_load,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_dest,
  input  logic              mem_wrv,
  input  logic              mem_wrs,
  input  logic              mem_load,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_dest,
  input  logic              wb_wrv,
  input  logic              wb_wrs,
  input  logic              mem_busy,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic              freeze_all,
  output logic [1:0]        fwd_vs1,
  output logic [1:0]        fwd_vs2,
  output logic [1:0]        fwd_ss1,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    LU      = 2'b01,
    MEMWAIT = 2'b10
  } state_t;

  // Count loaded on hazard detection; the detecting cycle is the first stall.
  localparam logic [1:0] LU_INIT = 2'(LOAD_STALL - 1);
  // Sources 0/1 are vector reads, source 2 is the scalar read.
  localparam logic [2:0] IS_VEC = 3'b011;

  state_t           state_reg, state_next;
  state_t           ret_reg, ret_next;
  state_t           eff_state;
  logic [1:0]       lu_cnt_reg, lu_cnt_next;
  logic [CNT_W-1:0] cnt_reg;

  logic [2:0][ADDR_W-1:0] src_addr;
  logic [2:0]             src_use;
  logic [2:0]             ex_hit;
  logic [2:0][1:0]        fwd_sel;
  logic                   hazard;
  logic                   stall_c, bubble_c, freeze_c;

  assign src_addr = {id_ss1, id_vs2, id_vs1};
  assign src_use  = {id_use_ss1, id_use_vs2, id_use_vs1};

  // Per-source match logic; the vector and scalar namespaces never alias.
  for (genvar gi = 0; gi < 3; gi++) begin : g_src
    logic ex_wr, mem_wr, wb_wr, mem_hit, wb_hit;
    assign ex_wr   = IS_VEC[gi] ? ex_wrv  : ex_wrs;
    assign mem_wr  = IS_VEC[gi] ? mem_wrv : mem_wrs;
    assign wb_wr   = IS_VEC[gi] ? wb_wrv  : wb_wrs;
    // Load data is not yet available in MEM, so it is never forwarded from there.
    assign mem_hit = mem_valid & mem_wr & ~mem_load & (mem_dest == src_addr[gi]);
    assign wb_hit  = wb_valid & wb_wr & (wb_dest == src_addr[gi]);
    assign ex_hit[gi]  = src_use[gi] & ex_wr & (ex_dest == src_addr[gi]);
    assign fwd_sel[gi] = mem_hit ? 2'b01 : (wb_hit ? 2'b10 : 2'b00);
  end

  assign hazard = id_valid & ex_valid & ex_load & (|ex_hit);

  // Next-state and Mealy stall outputs; MEMWAIT resumes as the saved state.
  always_comb begin
    state_next  = state_reg;
    ret_next    = ret_reg;
    lu_cnt_next = lu_cnt_reg;
    stall_c     = 1'b0;
    bubble_c    = 1'b0;
    freeze_c    = 1'b0;
    eff_state   = state_reg;
    if (state_reg == MEMWAIT && !mem_busy) begin
      eff_state = ret_reg;
    end
    case (eff_state)
      RUN: begin
        if (mem_busy) begin
          freeze_c   = 1'b1;
          ret_next   = RUN;
          state_next = MEMWAIT;
        end else if (hazard) begin
          stall_c     = 1'b1;
          bubble_c    = 1'b1;
          lu_cnt_next = LU_INIT;
          state_next  = (LOAD_STALL > 1) ? LU : RUN;
        end else begin
          state_next = RUN;
        end
      end
      LU: begin
        if (mem_busy) begin
          freeze_c   = 1'b1;
          ret_next   = LU;
          state_next = MEMWAIT;
        end else begin
          stall_c     = 1'b1;
          bubble_c    = 1'b1;
          lu_cnt_next = lu_cnt_reg - 2'd1;
          state_next  = (lu_cnt_reg == 2'd1) ? RUN : LU;
        end
      end
      MEMWAIT: begin
        freeze_c   = 1'b1;
        state_next = MEMWAIT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // State, return state, load-use counter and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      ret_reg    <= RUN;
      lu_cnt_reg <= 2'd0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      ret_reg    <= ret_next;
      lu_cnt_reg <= lu_cnt_next;
      if ((stall_c | freeze_c) && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  // Reset forces every output low regardless of the other inputs.
  assign stall_if   = rst ? 1'b0 : stall_c;
  assign bubble_ex  = rst ? 1'b0 : bubble_c;
  assign freeze_all = rst ? 1'b0 : freeze_c;
  assign fwd_vs1    = rst ? 2'b00 : fwd_sel[0];
  assign fwd_vs2    = rst ? 2'b00 : fwd_sel[1];
  assign fwd_ss1    = rst ? 2'b00 : fwd_sel[2];
  assign state      = rst ? 2'b00 : state_reg;
  assign stall_cnt  = rst ? '0 : cnt_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic.
// Expected outputs come from a cycle model tracking remaining stall cycles,
// a memory-wait flag and a saturating count; a monitor compares each cycle.
module tb_pipe_hazard_ctrl;
  localparam int AW  = 3;
  localparam int LS  = 2;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic id_valid, id_use_vs1, id_use_vs2, id_use_ss1;
  logic [AW-1:0] id_vs1, id_vs2, id_ss1, ex_dest, mem_dest, wb_dest;
  logic ex_valid, ex_wrv, ex_wrs, ex_load;
  logic mem_valid, mem_wrv, mem_wrs, mem_load;
  logic wb_valid, wb_wrv, wb_wrs, mem_busy;
  logic stall_if, bubble_ex, freeze_all;
  logic [1:0] fwd_vs1, fwd_vs2, fwd_ss1, state;
  logic [CW-1:0] stall_cnt;

  typedef struct packed {
    logic          s, b, f;
    logic [1:0]    v1, v2, s1, st;
    logic [CW-1:0] cnt;
  } out_t;

  out_t  exp_q[$];
  string tag_q[$];
  int    total = 0;
  int    bad   = 0;
  string tag   = "init";

  // Model state: remaining LU stall cycles, previous cycle was a memory freeze, count.
  int rem = 0;
  bit in_wait = 0;
  int cnt = 0;

  pipe_hazard_ctrl #(.ADDR_W(AW), .LOAD_STALL(LS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_vs1(id_vs1), .id_vs2(id_vs2),
    .id_use_vs1(id_use_vs1), .id_use_vs2(id_use_vs2), .id_ss1(id_ss1),
    .id_use_ss1(id_use_ss1), .ex_valid(ex_valid), .ex_dest(ex_dest), .ex_wrv(ex_wrv),
    .ex_wrs(ex_wrs), .ex_load(ex_load), .mem_valid(mem_valid), .mem_dest(mem_dest),
    .mem_wrv(mem_wrv), .mem_wrs(mem_wrs), .mem_load(mem_load), .wb_valid(wb_valid),
    .wb_dest(wb_dest), .wb_wrv(wb_wrv), .wb_wrs(wb_wrs), .mem_busy(mem_busy),
    .stall_if(stall_if), .bubble_ex(bubble_ex), .freeze_all(freeze_all),
    .fwd_vs1(fwd_vs1), .fwd_vs2(fwd_vs2), .fwd_ss1(fwd_ss1), .state(state),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic out_t dut_out();
    return '{s: stall_if, b: bubble_ex, f: freeze_all, v1: fwd_vs1, v2: fwd_vs2,
             s1: fwd_ss1, st: state, cnt: stall_cnt};
  endfunction

  // Forwarding choice for one source: newest non-load producer wins.
  function automatic logic [1:0] fwd_of(logic [AW-1:0] a, bit vec);
    if (mem_valid && (vec ? mem_wrv : mem_wrs) && !mem_load && mem_dest == a) return 2'b01;
    if (wb_valid && (vec ? wb_wrv : wb_wrs) && wb_dest == a) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit load_use();
    bit m;
    m = (id_use_vs1 && ex_wrv && ex_dest == id_vs1) ||
        (id_use_vs2 && ex_wrv && ex_dest == id_vs2) ||
        (id_use_ss1 && ex_wrs && ex_dest == id_ss1);
    return id_valid && ex_valid && ex_load && m;
  endfunction

  task automatic chk(string n, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, act, req);
    end
  endtask

  // Record the expected response for the current inputs, advance the model, next cycle.
  task automatic step();
    out_t e;
    e = '0;
    if (rst) begin
      rem = 0; in_wait = 0; cnt = 0;
    end else begin
      e.v1  = fwd_of(id_vs1, 1);
      e.v2  = fwd_of(id_vs2, 1);
      e.s1  = fwd_of(id_ss1, 0);
      e.st  = in_wait ? 2'b10 : (rem > 0 ? 2'b01 : 2'b00);
      e.cnt = CW'(cnt);
      if (mem_busy) e.f = 1'b1;
      else if (rem > 0) begin
        e.s = 1'b1; e.b = 1'b1; rem--;
      end else if (load_use()) begin
        e.s = 1'b1; e.b = 1'b1; rem = LS - 1;
      end
      in_wait = mem_busy;
      if ((e.s || e.f) && cnt < MAX) cnt++;
    end
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    {id_valid, id_use_vs1, id_use_vs2, id_use_ss1} = '0;
    {id_vs1, id_vs2, id_ss1, ex_dest, mem_dest, wb_dest} = '0;
    {ex_valid, ex_wrv, ex_wrs, ex_load} = '0;
    {mem_valid, mem_wrv, mem_wrs, mem_load} = '0;
    {wb_valid, wb_wrv, wb_wrs, mem_busy} = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; idle(); tag = "reset"; step(); rst = 1'b0;
  endtask

  task automatic set_lu_hazard();
    idle();
    id_valid = 1; ex_valid = 1; ex_load = 1; ex_wrv = 1; ex_dest = 5;
    id_vs2 = 5; id_use_vs2 = 1;
  endtask

  // Monitor: compares each recorded expectation with the DUT mid-cycle.
  always @(negedge clk) begin
    out_t e, a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = dut_out();
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sb_%s got=%h want=%h", t, a, e);
      end else begin
        $display("ok sb_%s out=%h", t, a);
      end
    end
  end

  initial begin
    rst = 1'b1; idle();
    @(posedge clk); #1;

    // Reset dominates busy memory, a live hazard and forwarding matches.
    set_lu_hazard();
    mem_busy = 1; mem_valid = 1; mem_wrv = 1; mem_dest = 3; id_vs1 = 3; id_use_vs1 = 1;
    tag = "rst_hold"; #1;
    chk("rst_outputs", int'(dut_out()), 0);
    step(); step();
    rst = 1'b0; idle(); tag = "rst_release"; #1;
    chk("rel_state", state, 0);
    chk("rel_cnt", stall_cnt, 0);
    step();

    // MEM beats WB; dropping MEM or making it a load falls back to WB.
    idle(); tag = "fwd";
    id_vs1 = 3; id_use_vs1 = 1;
    mem_valid = 1; mem_wrv = 1; mem_dest = 3; wb_valid = 1; wb_wrv = 1; wb_dest = 3; #1;
    chk("fwd_mem", fwd_vs1, 1); step();
    mem_valid = 0; #1;
    chk("fwd_wb", fwd_vs1, 2); step();
    mem_valid = 1; mem_load = 1; #1;
    chk("fwd_memload", fwd_vs1, 2); step();
    mem_load = 0; mem_wrv = 0; mem_wrs = 1; wb_wrv = 0; wb_wrs = 1; #1;
    chk("fwd_nsalias", fwd_vs1, 0);
    chk("fwd_scalar", fwd_ss1, 0); step();

    // Load-use stall of two cycles.
    do_reset(); set_lu_hazard(); tag = "lu"; #1;
    chk("lu_c0_stall", {stall_if, bubble_ex, freeze_all}, 3'b110); step();
    chk("lu_c1_stall", {stall_if, bubble_ex, freeze_all}, 3'b110);
    chk("lu_c1_state", state, 1); step();
    ex_load = 0; #1;
    chk("lu_done", stall_if, 0);
    chk("lu_cnt", stall_cnt, 2); step();

    // Memory busy for three cycles in the middle of the load-use stall.
    do_reset(); set_lu_hazard(); tag = "lu_busy"; #1;
    chk("lb_c0", {stall_if, bubble_ex}, 2'b11); step();
    mem_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1; chk("lb_frz", {stall_if, bubble_ex, freeze_all}, 3'b001); step();
    end
    mem_busy = 0; #1;
    chk("lb_resume", {stall_if, bubble_ex, freeze_all}, 3'b110);
    chk("lb_state", state, 2); step();
    ex_load = 0; #1;
    chk("lb_done", stall_if, 0);
    chk("lb_cnt", stall_cnt, 5); step();

    // A scalar write does not create a hazard on a vector read.
    idle(); tag = "ns_haz";
    id_valid = 1; ex_valid = 1; ex_load = 1; ex_wrs = 1; ex_dest = 5; id_vs1 = 5; id_use_vs1 = 1; #1;
    chk("ns_stall", stall_if, 0);
    chk("ns_fwd", fwd_vs1, 0); step();

    // Saturation of the stall counter during a long memory wait.
    do_reset(); tag = "sat"; mem_busy = 1;
    for (int i = 0; i < 20; i++) step();
    mem_busy = 0; #1;
    chk("sat_cnt", stall_cnt, MAX);
    chk("sat_frz_drop", freeze_all, 0); step();

    // Random traffic with a small address range to provoke matches.
    tag = "rand";
    for (int n = 0; n < 600; n++) begin
      rst        = ($urandom_range(0, 39) == 0);
      id_valid   = $urandom_range(0, 3) != 0;
      id_vs1     = AW'($urandom_range(0, 3));
      id_vs2     = AW'($urandom_range(0, 3));
      id_ss1     = AW'($urandom_range(0, 3));
      id_use_vs1 = $urandom_range(0, 1);
      id_use_vs2 = $urandom_range(0, 1);
      id_use_ss1 = $urandom_range(0, 1);
      ex_valid   = $urandom_range(0, 3) != 0;
      ex_dest    = AW'($urandom_range(0, 3));
      ex_wrv     = $urandom_range(0, 1);
      ex_wrs     = $urandom_range(0, 1);
      ex_load    = $urandom_range(0, 1);
      mem_valid  = $urandom_range(0, 1);
      mem_dest   = AW'($urandom_range(0, 3));
      mem_wrv    = $urandom_range(0, 1);
      mem_wrs    = $urandom_range(0, 1);
      mem_load   = $urandom_range(0, 2) == 0;
      wb_valid   = $urandom_range(0, 1);
      wb_dest    = AW'($urandom_range(0, 3));
      wb_wrv     = $urandom_range(0, 1);
      wb_wrs     = $urandom_range(0, 1);
      mem_busy   = $urandom_range(0, 4) == 0;
      step();
    end
    rst = 1'b0; idle();

    // Let the monitor drain, bounded.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
